// File: rtl/rr_mux_k_to_1.sv
// Registered K-to-1 mux with round-robin arbitration and valid/ready on every port.
// Define RRMUX_FIXED_PRIORITY_EN to replace round-robin with fixed lowest-index priority.
module rr_mux_k_to_1 #(
  parameter int unsigned K    = 4,
  parameter int unsigned SIZE = 16,
  parameter int unsigned BIT  = $clog2(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [K-1:0]    in_valid,
  input  logic [K*SIZE-1:0] in_data,
  output logic [K-1:0]    in_ready,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic [BIT-1:0]  out_sel,
  input  logic            out_ready
);

  logic [BIT-1:0] ptr;
  logic [BIT-1:0] g;
  logic [BIT:0]   idx;
  logic           found;
  logic           load;
  logic [K-1:0]   grant;

  assign load = !out_valid | out_ready;

  // Scan channels starting at ptr, wrapping at K; the first valid one wins.
  always_comb begin
    grant = '0;
    g     = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < K; i++) begin
      idx = {1'b0, ptr} + (BIT+1)'(i);
      if (idx >= (BIT+1)'(K)) begin
        idx = idx - (BIT+1)'(K);
      end
      if (!found && in_valid[idx[BIT-1:0]]) begin
        found = 1'b1;
        g     = idx[BIT-1:0];
      end
    end
    if (found) begin
      grant[g] = 1'b1;
    end
  end

  assign in_ready = grant & {K{load}};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[g*SIZE +: SIZE];
        out_sel   <= g;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RRMUX_FIXED_PRIORITY_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && found) begin
      ptr <= (g == BIT'(K-1)) ? '0 : g + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_k_to_1.sv
// Bench for rr_mux_k_to_1: behavioural model compared every cycle, plus directed literal checks.
module tb_rr_mux_k_to_1;

`ifdef RRMUX_FIXED_PRIORITY_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic        b_rst;
  logic [2:0]  b_in_valid;
  logic [47:0] b_in_data;
  logic [2:0]  b_in_ready;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  rr_mux_k_to_1 #(.K(4), .SIZE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_mux_k_to_1 #(.K(3), .SIZE(16)) dut3 (
    .clk       (clk),
    .rst       (b_rst),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_ready (b_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: first valid channel at or after p, counting modulo 4.
  function automatic int winner(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input logic [3:0] v, input int p,
                                           input bit mv, input logic ordy);
    int w;
    w = winner(v, p);
    if (w < 0 || (mv && !ordy)) return 4'b0000;
    return 4'b0001 << w;
  endfunction

  bit          m_valid = 1'b0;
  logic [15:0] m_data  = '0;
  int          m_sel   = 0;
  int          m_ptr   = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      m_ptr   <= 0;
      started <= 1'b1;
    end else if (!m_valid || out_ready) begin
      if (winner(in_valid, m_ptr) >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[winner(in_valid, m_ptr)*16 +: 16];
        m_sel   <= winner(in_valid, m_ptr);
        if (!Fixed) m_ptr <= (winner(in_valid, m_ptr) + 1) % 4;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("model out_data", {16'b0, out_data}, {16'b0, m_data});
      chk("model out_sel", {30'b0, out_sel}, m_sel);
      chk("model in_ready", {28'b0, in_ready},
          {28'b0, exp_ready(in_valid, m_ptr, m_valid, out_ready)});
    end
  end

  initial begin
    int es;
    rst         = 1'b1;
    in_valid    = 4'hF;
    in_data     = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    out_ready   = 1'b1;
    b_rst       = 1'b1;
    b_in_valid  = 3'b000;
    b_in_data   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    b_out_ready = 1'b1;

    cyc();
    cyc();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_data", {16'b0, out_data}, 32'h0000);
    chk("reset out_sel", {30'b0, out_sel}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {28'b0, in_ready}, 32'b0001);

    in_valid = 4'b0100;
    cyc();
    chk("single out_valid", {31'b0, out_valid}, 32'd1);
    chk("single out_data", {16'b0, out_data}, 32'hCCCC);
    chk("single out_sel", {30'b0, out_sel}, 32'd2);
    in_valid = 4'b0000;
    cyc();
    chk("single drain out_valid", {31'b0, out_valid}, 32'd0);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      es = Fixed ? 0 : i % 4;
      chk("full out_sel", {30'b0, out_sel}, es);
      chk("full out_data", {16'b0, out_data}, 32'hAAAA + es * 32'h1111);
      chk("full out_valid", {31'b0, out_valid}, 32'd1);
    end

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall in_ready", {28'b0, in_ready}, 32'd0);
      cyc();
      chk("stall out_data", {16'b0, out_data}, Fixed ? 32'hAAAA : 32'hBBBB);
    end
    out_ready = 1'b1;
    cyc();
    chk("resume out_sel", {30'b0, out_sel}, Fixed ? 32'd0 : 32'd2);
    chk("resume out_data", {16'b0, out_data}, Fixed ? 32'hAAAA : 32'hCCCC);

    if (Fixed) begin
      in_valid = 4'b1110;
      cyc();
      chk("fixed drop0 out_sel", {30'b0, out_sel}, 32'd1);
    end

    repeat (3000) begin
      in_valid  = 4'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 97) == 0;
      cyc();
    end
    rst = 1'b0;
    in_valid = 4'h0;
    cyc();

    b_in_valid = 3'b111;
    cyc();
    b_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("k3 out_sel", {30'b0, b_out_sel}, Fixed ? 0 : i % 3);
      chk("k3 out_data", {16'b0, b_out_data}, 32'hAAAA + (Fixed ? 0 : i % 3) * 32'h1111);
    end
    b_out_ready = 1'b0;
    cyc();
    chk("k3 stall out_sel", {30'b0, b_out_sel}, Fixed ? 32'd0 : 32'd1);
    b_rst = 1'b1;
    cyc();
    chk("k3 reset out_valid", {31'b0, b_out_valid}, 32'd0);
    b_rst = 1'b0;
    b_out_ready = 1'b1;
    #1;
    chk("k3 post-reset in_ready", {29'b0, b_in_ready}, 32'b001);
    cyc();
    chk("k3 first grant out_sel", {30'b0, b_out_sel}, 32'd0);
    chk("k3 first grant out_valid", {31'b0, b_out_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
